// File: rtl/ps2_pkg.sv
// Shared constants for the PS/2 keyboard receiver: FSM encodings, prefix bytes,
// FIFO entry layout and error-flag bit positions.
package ps2_pkg;

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StData   = 2'd1;
  localparam logic [1:0] StParity = 2'd2;
  localparam logic [1:0] StStop   = 2'd3;

  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;

  localparam int unsigned ENTRY_W   = 10;
  localparam int unsigned ENTRY_BRK = 8;
  localparam int unsigned ENTRY_EXT = 9;

  localparam int unsigned ERR_PARITY  = 0;
  localparam int unsigned ERR_TIMEOUT = 1;

  function automatic logic [ENTRY_W-1:0] make_entry(input logic ext, input logic brk,
                                                    input logic [7:0] code);
    return {ext, brk, code};
  endfunction

endpackage

// File: rtl/ps2_code_fifo.sv
// Generic synchronous circular FIFO with show-ahead head output and occupancy count.
// A pop on a full FIFO frees the slot so a same-cycle push is accepted.
module ps2_code_fifo #(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [AW:0]      count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= wdata;
  end

  assign rdata = mem[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/ps2_keyboard_receiver.sv
// Oversampling PS/2 keyboard receiver: synchronises and deglitches the PS/2 lines,
// deframes 11-bit frames, folds E0/F0 prefixes into flags and queues codes in a FIFO.
module ps2_keyboard_receiver
  import ps2_pkg::*;
#(
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 50000,
  parameter int unsigned FIFO_DEPTH     = 8,
  parameter int unsigned FIFO_AW        = 3
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               iPS2_CLK,
  input  logic               iPS2_DATA,
  input  logic               iRead,
  input  logic               iClearErr,
  output logic               oValid,
  output logic [7:0]         oCode,
  output logic               oBreak,
  output logic               oExtended,
  output logic [FIFO_AW:0]   oCount,
  output logic               oErr,
  output logic [1:0]         oErrFlags,
  output logic               oOverflow
);

  localparam int unsigned FW = $clog2(FILTER_LEN) + 1;
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES) + 1;

  logic [1:0]         clk_sync, data_sync;
  logic               clk_s, data_s;
  logic [FW-1:0]      filt_cnt;
  logic               filt_clk, filt_prev, fall;
  logic [1:0]         state_q, state_d;
  logic [2:0]         bitcnt_q, bitcnt_d;
  logic [7:0]         shreg_q, shreg_d;
  logic               par_q, par_d;
  logic [TW-1:0]      to_cnt_q;
  logic               frame_ok, frame_bad, timeout;
  logic               rx_vld_q;
  logic [7:0]         rx_byte_q;
  logic               ext_q, brk_q;
  logic               push;
  logic [ENTRY_W-1:0] entry, head;
  logic [FIFO_AW:0]   fifo_count;
  logic               fifo_full, fifo_empty;
  logic               err_q, overflow_q;
  logic [1:0]         err_flags_q, err_flags_d;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
    end else begin
      clk_sync  <= {clk_sync[0], iPS2_CLK};
      data_sync <= {data_sync[0], iPS2_DATA};
    end
  end

  assign clk_s  = clk_sync[1];
  assign data_s = data_sync[1];

  // Filtered clock only follows the line after FILTER_LEN consecutive differing samples.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      filt_cnt  <= '0;
      filt_clk  <= 1'b1;
      filt_prev <= 1'b1;
    end else begin
      filt_prev <= filt_clk;
      if (clk_s == filt_clk) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
        filt_clk <= clk_s;
        filt_cnt <= '0;
      end else begin
        filt_cnt <= filt_cnt + FW'(1);
      end
    end
  end

  assign fall = filt_prev & ~filt_clk;

  always_comb begin
    state_d   = state_q;
    bitcnt_d  = bitcnt_q;
    shreg_d   = shreg_q;
    par_d     = par_q;
    frame_ok  = 1'b0;
    frame_bad = 1'b0;
    timeout   = 1'b0;
    if (fall) begin
      unique case (state_q)
        StIdle: begin
          if (!data_s) begin
            state_d  = StData;
            bitcnt_d = 3'd0;
          end
        end
        StData: begin
          shreg_d  = {data_s, shreg_q[7:1]};
          bitcnt_d = bitcnt_q + 3'd1;
          if (bitcnt_q == 3'd7) state_d = StParity;
        end
        StParity: begin
          par_d   = data_s;
          state_d = StStop;
        end
        StStop: begin
          state_d = StIdle;
          if (data_s && ((^shreg_q) ^ par_q)) frame_ok = 1'b1;
          else                                frame_bad = 1'b1;
        end
        default: state_d = StIdle;
      endcase
    end else if (state_q != StIdle && to_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
      timeout = 1'b1;
      state_d = StIdle;
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q   <= StIdle;
      bitcnt_q  <= '0;
      shreg_q   <= '0;
      par_q     <= 1'b0;
      to_cnt_q  <= '0;
      rx_vld_q  <= 1'b0;
      rx_byte_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      bitcnt_q <= bitcnt_d;
      shreg_q  <= shreg_d;
      par_q    <= par_d;
      to_cnt_q <= (fall || state_q == StIdle) ? '0 : to_cnt_q + TW'(1);
      rx_vld_q <= frame_ok;
      if (frame_ok) rx_byte_q <= shreg_q;
      err_q    <= frame_bad | timeout;
    end
  end

  // Prefix bytes only update flags; any other code is queued with the pending flags.
  assign push  = rx_vld_q && (rx_byte_q != PS2_EXT) && (rx_byte_q != PS2_BRK);
  assign entry = make_entry(ext_q, brk_q, rx_byte_q);

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      ext_q <= 1'b0;
      brk_q <= 1'b0;
    end else if (frame_bad || timeout) begin
      ext_q <= 1'b0;
      brk_q <= 1'b0;
    end else if (rx_vld_q) begin
      if (rx_byte_q == PS2_EXT) begin
        ext_q <= 1'b1;
      end else if (rx_byte_q == PS2_BRK) begin
        brk_q <= 1'b1;
      end else begin
        ext_q <= 1'b0;
        brk_q <= 1'b0;
      end
    end
  end

  ps2_code_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH),
    .AW    (FIFO_AW)
  ) u_fifo (
    .clk   (Clock),
    .rst_n (Reset),
    .push  (push),
    .pop   (iRead),
    .wdata (entry),
    .rdata (head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    err_flags_d = iClearErr ? 2'b00 : err_flags_q;
    if (frame_bad) err_flags_d[ERR_PARITY]  = 1'b1;
    if (timeout)   err_flags_d[ERR_TIMEOUT] = 1'b1;
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      err_flags_q <= 2'b00;
      overflow_q  <= 1'b0;
    end else begin
      err_flags_q <= err_flags_d;
      if (push && fifo_full && !iRead) overflow_q <= 1'b1;
      else if (iClearErr)              overflow_q <= 1'b0;
    end
  end

  assign oValid    = ~fifo_empty;
  assign oCode     = oValid ? head[7:0] : 8'h00;
  assign oBreak    = oValid & head[ENTRY_BRK];
  assign oExtended = oValid & head[ENTRY_EXT];
  assign oCount    = fifo_count;
  assign oErr      = err_q;
  assign oErrFlags = err_flags_q;
  assign oOverflow = overflow_q;

endmodule

// File: tb/tb_ps2_keyboard_receiver.sv
// Directed self-checking bench for ps2_keyboard_receiver with a fast PS/2 clock.
module tb_ps2_keyboard_receiver;

  localparam int unsigned FILTER_LEN = 8;
  localparam int unsigned TIMEOUT    = 200;
  localparam int unsigned HALF       = 20;

  logic       clk, rst_n, ps2_clk, ps2_data, rd, clr;
  logic       valid, brk, ext, err, ovf;
  logic [7:0] code;
  logic [3:0] count;
  logic [1:0] flags;

  int checks = 0;
  int errors = 0;
  int err_pulses = 0;
  int e0;

  ps2_keyboard_receiver #(
    .FILTER_LEN     (FILTER_LEN),
    .TIMEOUT_CYCLES (TIMEOUT),
    .FIFO_DEPTH     (8),
    .FIFO_AW        (3)
  ) dut (
    .Clock     (clk),
    .Reset     (rst_n),
    .iPS2_CLK  (ps2_clk),
    .iPS2_DATA (ps2_data),
    .iRead     (rd),
    .iClearErr (clr),
    .oValid    (valid),
    .oCode     (code),
    .oBreak    (brk),
    .oExtended (ext),
    .oCount    (count),
    .oErr      (err),
    .oErrFlags (flags),
    .oOverflow (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (err) err_pulses++;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1);
  end

  task automatic ps2_bit(input logic b);
    @(posedge clk); ps2_data = b;
    repeat (HALF) @(posedge clk);
    ps2_clk = 1'b0;
    repeat (HALF) @(posedge clk);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] c, input logic bad_par);
    logic [10:0] bits;
    bits = {1'b1, ~(^c) ^ bad_par, c, 1'b0};
    for (int i = 0; i < 11; i++) ps2_bit(bits[i]);
    ps2_data = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic pulse_read();
    @(posedge clk); rd = 1'b1;
    @(posedge clk); rd = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulse_clear();
    @(posedge clk); clr = 1'b1;
    @(posedge clk); clr = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ps2_clk = 1'b1; ps2_data = 1'b1; rd = 1'b0; clr = 1'b0;
    repeat (5) @(posedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({valid, code, brk, ext, count, err, flags, ovf} !== 19'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h want 0", {valid, code, brk, ext, count, err, flags, ovf});
    end
  endtask

  task automatic test_good_frame();
    send_frame(8'h1C, 1'b0);
    checks++;
    if ({valid, code, brk, ext} !== {1'b1, 8'h1C, 2'b00}) begin
      errors++; $display("FAIL good_head: got %b %h %b %b want 1 1c 0 0", valid, code, brk, ext);
    end
    checks++;
    if (count !== 4'd1) begin errors++; $display("FAIL good_count: got %0d want 1", count); end
    pulse_read();
    checks++;
    if (valid !== 1'b0 || count !== 4'd0) begin
      errors++; $display("FAIL good_read: got valid %b count %0d want 0 0", valid, count);
    end
  endtask

  task automatic test_prefix();
    send_frame(8'hF0, 1'b0);
    send_frame(8'h1C, 1'b0);
    checks++;
    if ({count, code, brk, ext} !== {4'd1, 8'h1C, 2'b10}) begin
      errors++; $display("FAIL break_entry: got %0d %h %b %b want 1 1c 1 0", count, code, brk, ext);
    end
    pulse_read();
    send_frame(8'hE0, 1'b0);
    send_frame(8'hF0, 1'b0);
    send_frame(8'h75, 1'b0);
    checks++;
    if ({count, code, brk, ext} !== {4'd1, 8'h75, 2'b11}) begin
      errors++; $display("FAIL ext_break_entry: got %0d %h %b %b want 1 75 1 1", count, code, brk, ext);
    end
    pulse_read();
  endtask

  task automatic test_parity_error();
    e0 = err_pulses;
    send_frame(8'h1C, 1'b1);
    checks++;
    if (count !== 4'd0 || flags !== 2'b01 || err_pulses - e0 != 1) begin
      errors++;
      $display("FAIL parity_err: got count %0d flags %b pulses %0d want 0 01 1",
               count, flags, err_pulses - e0);
    end
    pulse_clear();
    checks++;
    if (flags !== 2'b00) begin errors++; $display("FAIL parity_clear: got %b want 00", flags); end
    send_frame(8'hE0, 1'b0);
    send_frame(8'h33, 1'b1);
    send_frame(8'h1C, 1'b0);
    checks++;
    if ({count, code, brk, ext} !== {4'd1, 8'h1C, 2'b00}) begin
      errors++; $display("FAIL err_clears_ext: got %0d %h %b %b want 1 1c 0 0", count, code, brk, ext);
    end
    pulse_read();
    pulse_clear();
  endtask

  task automatic test_timeout();
    e0 = err_pulses;
    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(i[0]);
    ps2_data = 1'b1;
    repeat (TIMEOUT + 60) @(posedge clk);
    @(negedge clk);
    checks++;
    if (flags !== 2'b10 || err_pulses - e0 != 1 || count !== 4'd0) begin
      errors++;
      $display("FAIL timeout: got flags %b pulses %0d count %0d want 10 1 0",
               flags, err_pulses - e0, count);
    end
    send_frame(8'h29, 1'b0);
    checks++;
    if ({count, code, brk, ext} !== {4'd1, 8'h29, 2'b00}) begin
      errors++; $display("FAIL after_timeout: got %0d %h %b %b want 1 29 0 0", count, code, brk, ext);
    end
    pulse_read();
    pulse_clear();
    checks++;
    if (flags !== 2'b00) begin errors++; $display("FAIL timeout_clear: got %b want 00", flags); end
  endtask

  task automatic test_overflow();
    for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b0);
    checks++;
    if (count !== 4'd8 || ovf !== 1'b1) begin
      errors++; $display("FAIL overflow: got count %0d ovf %b want 8 1", count, ovf);
    end
    for (int i = 1; i <= 8; i++) begin
      checks++;
      if (valid !== 1'b1 || code !== 8'(i)) begin
        errors++; $display("FAIL fifo_order: got %b %h want 1 %h", valid, code, 8'(i));
      end
      pulse_read();
    end
    checks++;
    if (valid !== 1'b0 || count !== 4'd0) begin
      errors++; $display("FAIL fifo_drained: got %b %0d want 0 0", valid, count);
    end
    pulse_clear();
    checks++;
    if (ovf !== 1'b0) begin errors++; $display("FAIL overflow_clear: got %b want 0", ovf); end
  endtask

  task automatic test_glitch_and_reset();
    e0 = err_pulses;
    @(posedge clk); ps2_data = 1'b0; ps2_clk = 1'b0;
    repeat (FILTER_LEN - 2) @(posedge clk);
    ps2_clk = 1'b1; ps2_data = 1'b1;
    repeat (TIMEOUT + 60) @(posedge clk);
    @(negedge clk);
    checks++;
    if (err_pulses != e0 || flags !== 2'b00 || count !== 4'd0) begin
      errors++;
      $display("FAIL glitch: got pulses %0d flags %b count %0d want 0 00 0",
               err_pulses - e0, flags, count);
    end
    send_frame(8'h44, 1'b0);
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b0);
    @(posedge clk); rst_n = 1'b0; ps2_data = 1'b1;
    repeat (5) @(posedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    checks++;
    if ({valid, code, brk, ext, count, err, flags, ovf} !== 19'd0) begin
      errors++;
      $display("FAIL reset_midframe: got %h want 0", {valid, code, brk, ext, count, err, flags, ovf});
    end
    e0 = err_pulses;
    send_frame(8'h5A, 1'b0);
    checks++;
    if ({count, code, brk, ext} !== {4'd1, 8'h5A, 2'b00} || err_pulses != e0) begin
      errors++;
      $display("FAIL after_reset: got %0d %h %b %b pulses %0d want 1 5a 0 0 0",
               count, code, brk, ext, err_pulses - e0);
    end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_prefix();
    test_parity_error();
    test_timeout();
    test_overflow();
    test_glitch_and_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
